// File: rtl/video_stream_pkg.sv
// Shared definitions for the vsync/hsync/valid/data video stream: analyzer state,
// error bit positions and the default 800x600 timing used by generator and sink.
package video_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int ERR_XRES = 0;
    localparam int ERR_YRES = 1;
    localparam int ERR_HTOT = 2;
    localparam int ERR_VTOT = 3;

    localparam int DEF_H_DISP  = 800;
    localparam int DEF_V_DISP  = 600;
    localparam int DEF_H_TOTAL = 1056;
    localparam int DEF_V_TOTAL = 628;
    localparam int DEF_DW      = 24;

endpackage

// File: rtl/video_stream_analyzer_if.sv
// Video stream bundle: frame sync, line sync, pixel qualifier and pixel data.
interface video_stream_analyzer_if
    import video_stream_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic          vsync;
    logic          hsync;
    logic          valid;
    logic [DW-1:0] data;

    modport master (output vsync, hsync, valid, data);
    modport slave  (input  vsync, hsync, valid, data);

endinterface

// File: rtl/video_stream_analyzer_sync_edge_det.sv
// Registers a sync input once and flags its rising edge on the registered copy.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);
    logic sig_p1;
    logic sig_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_p1 <= 1'b0;
            sig_p2 <= 1'b0;
        end else begin
            sig_p1 <= sig;
            sig_p2 <= sig_p1;
        end
    end

    assign rise = sig_p1 & ~sig_p2;

endmodule

// File: rtl/video_stream_analyzer.sv
// Stream sink that measures per-frame resolution, line/frame periods and a pixel
// checksum, flags deviations from the expected timing and reports lock.
module video_stream_analyzer
    import video_stream_pkg::*;
#(
    parameter int H_DISP  = DEF_H_DISP,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int DW      = DEF_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    video_stream_analyzer_if.slave  vin,
    output logic [15:0]             meas_xres,
    output logic [15:0]             meas_yres,
    output logic [15:0]             meas_htotal,
    output logic [15:0]             meas_vtotal,
    output logic [31:0]             frame_sum,
    output logic [15:0]             frame_cnt,
    output logic [3:0]              err,
    output logic                    frame_done,
    output logic                    locked
);
    localparam logic [15:0] H_DISP_C  = 16'(H_DISP);
    localparam logic [15:0] V_DISP_C  = 16'(V_DISP);
    localparam logic [15:0] H_TOTAL_C = 16'(H_TOTAL);
    localparam logic [15:0] V_TOTAL_C = 16'(V_TOTAL);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p1: input register; sync edges are found on p1 against p2
    logic          vs_rise;
    logic          hs_rise;
    logic          vld_p1;
    logic [DW-1:0] data_p1;

    sync_edge_det u_vs_edge (.clk(clk), .rst_n(rst_n), .sig(vin.vsync), .rise(vs_rise));
    sync_edge_det u_hs_edge (.clk(clk), .rst_n(rst_n), .sig(vin.hsync), .rise(hs_rise));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vin.valid;
            data_p1 <= vin.data;
        end
    end

    state_t      state;
    logic [15:0] hcnt;
    logic [15:0] lcnt;
    logic [15:0] pcnt;
    logic [15:0] acnt;
    logic [15:0] xres_cap;
    logic [15:0] htot_cap;
    logic        seen_h;
    logic        htot_done;
    logic        err_x;
    logic        err_h;
    logic [31:0] sum;
    logic        prev_clean;

    logic        line_active;
    logic        period_end;
    logic [15:0] acnt_nxt;
    logic [15:0] xres_nxt;
    logic [15:0] htot_nxt;
    logic        err_x_nxt;
    logic        err_h_nxt;
    logic [3:0]  err_nxt;

    // A coincident hsync/vsync rise closes the line once; for htotal it opens the new frame
    assign line_active = (state == MEAS) && (hs_rise || vs_rise) && (pcnt != 16'd0);
    assign period_end  = (state == MEAS) && hs_rise && !vs_rise && seen_h;
    assign acnt_nxt    = line_active ? sat_inc(acnt) : acnt;
    assign xres_nxt    = (line_active && acnt == 16'd0) ? pcnt : xres_cap;
    assign err_x_nxt   = err_x | (line_active && pcnt != H_DISP_C);
    assign htot_nxt    = (period_end && !htot_done) ? hcnt : htot_cap;
    assign err_h_nxt   = err_h | (period_end && hcnt != H_TOTAL_C);

    always_comb begin
        err_nxt           = '0;
        err_nxt[ERR_XRES] = err_x_nxt;
        err_nxt[ERR_YRES] = (acnt_nxt != V_DISP_C);
        err_nxt[ERR_HTOT] = err_h;
        err_nxt[ERR_VTOT] = (lcnt != V_TOTAL_C);
    end

    // Stage p2: frame counters and the result registers published on frame_done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            lcnt        <= '0;
            pcnt        <= '0;
            acnt        <= '0;
            xres_cap    <= '0;
            htot_cap    <= '0;
            seen_h      <= 1'b0;
            htot_done   <= 1'b0;
            err_x       <= 1'b0;
            err_h       <= 1'b0;
            sum         <= '0;
            prev_clean  <= 1'b0;
            meas_xres   <= '0;
            meas_yres   <= '0;
            meas_htotal <= '0;
            meas_vtotal <= '0;
            frame_sum   <= '0;
            frame_cnt   <= '0;
            err         <= '0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vs_rise) begin
                if (state == MEAS) begin
                    meas_xres   <= xres_nxt;
                    meas_yres   <= acnt_nxt;
                    meas_htotal <= htot_cap;
                    meas_vtotal <= lcnt;
                    frame_sum   <= sum;
                    err         <= err_nxt;
                    frame_cnt   <= frame_cnt + 16'd1;
                    frame_done  <= 1'b1;
                    prev_clean  <= (err_nxt == 4'd0);
                    if (err_nxt != 4'd0)
                        locked <= 1'b0;
                    else if (prev_clean)
                        locked <= 1'b1;
                end
                state     <= MEAS;
                hcnt      <= 16'd1;
                seen_h    <= hs_rise;
                lcnt      <= hs_rise ? 16'd1 : 16'd0;
                pcnt      <= vld_p1 ? 16'd1 : 16'd0;
                acnt      <= '0;
                xres_cap  <= '0;
                htot_cap  <= '0;
                htot_done <= 1'b0;
                err_x     <= 1'b0;
                err_h     <= 1'b0;
                sum       <= vld_p1 ? 32'(data_p1) : 32'd0;
            end else if (state == MEAS) begin
                hcnt <= hs_rise ? 16'd1 : sat_inc(hcnt);
                if (hs_rise) begin
                    seen_h <= 1'b1;
                    lcnt   <= sat_inc(lcnt);
                    pcnt   <= vld_p1 ? 16'd1 : 16'd0;
                end else if (vld_p1) begin
                    pcnt <= sat_inc(pcnt);
                end
                if (period_end)
                    htot_done <= 1'b1;
                acnt     <= acnt_nxt;
                xres_cap <= xres_nxt;
                htot_cap <= htot_nxt;
                err_x    <= err_x_nxt;
                err_h    <= err_h_nxt;
                if (vld_p1)
                    sum <= sum + 32'(data_p1);
            end
        end
    end

endmodule

// File: doc/video_stream_analyzer.md
# video_stream_analyzer

Synthesizable receive-side endpoint for the team's vsync/hsync/valid/data video stream, the sink counterpart of the stream generator. It sits on any stream tap, for example the camera input or the output of `fram_diff_top`. Per frame it measures active resolution, line and frame periods, and a pixel checksum. It flags deviations from the expected timing parameters and reports lock status, all on one clock domain.

## Interface
- `H_DISP`, 800, expected valid pixels per active line
- `V_DISP`, 600, expected active lines per frame
- `H_TOTAL`, 1056, expected clocks per line (hsync rise to hsync rise)
- `V_TOTAL`, 628, expected lines per frame
- `DW`, 24, pixel data width
- `clk` in 1: sole clock
- `rst_n` in 1: reset, synchronous, active-low
- `vin_vsync` in 1: frame sync, active-high; the rising edge marks the frame start
- `vin_hsync` in 1: line sync, active-high; the rising edge marks the line start
- `vin_valid` in 1: pixel qualifier
- `vin_data` in DW: pixel
- `meas_xres` out 16: valid count of the first active line of the last completed frame
- `meas_yres` out 16: active lines in the last frame
- `meas_htotal` out 16: period of the first complete line
- `meas_vtotal` out 16: lines in the last frame
- `frame_sum` out 32: sum of zero-extended `vin_data` over valid pixels, mod 2^32
- `frame_cnt` out 16: completed frames, wraps
- `err` out 4: [0] xres, [1] yres, [2] htotal, [3] vtotal mismatch
- `frame_done` out 1: one-cycle pulse when all `meas_*`, `frame_sum` and `err` update
- `locked` out 1: two consecutive error-free frames

## Operation
- Input stage: all inputs are registered once (d1). Rising edges are detected on d1 against d2.
- States:
  - `IDLE`: entered from reset. Moves to `MEAS` on the first vsync rise and clears all counters; no `frame_done` is produced.
  - `MEAS`: every later vsync rise closes the frame, latches results, pulses `frame_done`, clears counters and stays in `MEAS`.
- Line start = hsync rise. Line close = next hsync rise or vsync rise; a coincident hsync and vsync rise closes the line only once.
- `hcnt`: clocks since the last hsync rise. At each hsync rise that follows an earlier hsync rise in the same frame:
  - the first such period is captured as htotal;
  - any period different from `H_TOTAL` sets sticky err[2].
- `lcnt`: counts hsync rises within the window [opening vsync rise, closing vsync rise), including an edge coincident with the opening vsync rise and excluding one at the closing rise. At close, `meas_vtotal = lcnt` and err[3] = (lcnt != `V_TOTAL`).
- `pcnt`: counts valid pixels per line. A valid in the same cycle as a line-start edge belongs to the new line. At line close with `pcnt` > 0:
  - increment `acnt`;
  - if it is the first active line, capture `pcnt` as xres;
  - if `pcnt` != `H_DISP`, set sticky err[0].
- At frame close: err[1] = (`acnt` != `V_DISP`). The closing line's contribution is folded in combinationally in the same cycle.
- All counters are 16-bit and saturate at 0xFFFF; the checksum wraps.
- `locked`:
  - set on `frame_done` with err == 0 when the previous frame also had err == 0;
  - cleared on any `frame_done` with err != 0.
- `vin_vsync` held high for many cycles: only the rising edge is acted on. Valids while vsync is high are counted normally.

## Timing
- Reset values: all outputs 0, `locked` 0, state `IDLE`.
- Reset asserted mid-frame: everything returns to reset values on the next edge; a partial frame produces no `frame_done`.
- `frame_done` is high exactly 2 clocks after the cycle in which `vin_vsync` first samples high: 1 for the input register, 1 for the output register. Outputs change in that same cycle and hold until the next `frame_done`.
- No back-pressure; the block accepts 1 pixel per clock continuously.

## Structure
- Package `video_stream_pkg`:
  - state enum (`IDLE`, `MEAS`);
  - `ERR_XRES`, `ERR_YRES`, `ERR_HTOT`, `ERR_VTOT` bit indices;
  - 800x600 default timing constants, shared with the generator.
- Sub-module `sync_edge_det`: input register plus rising-edge pulse, instantiated for vsync and for hsync.

## Test plan
- Nominal 800x600 stream (1056/628), 4 vsync edges:
  - 3 `frame_done` pulses;
  - each shows 800/600/1056/628, err = 0;
  - `locked` rises at the 2nd pulse;
  - `frame_cnt` = 3.
- `vin_data` = 0x000001 on every valid -> `frame_sum` = 0x00075300 (480000).
- Line 10 carries 799 valids:
  - that frame: err = 4'b0001, `meas_xres` = 800, `locked` drops;
  - relocks after two clean frames.
- Line 20 period 1055 clocks (next line 1057) -> err = 4'b0100 with all other fields nominal.
- 640x480 stream (800/525 totals) on default parameters -> `meas_*` = 640/480/800/525, err = 4'b1111.
- `rst_n` low for 3 clocks mid-frame:
  - all outputs 0;
  - the next vsync rise gives no `frame_done`;
  - the following rise gives a correct pulse.
